regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the single-write, two-read CPU register file in the pipelined datapath.
- Configurable data width, address width and number of read ports.
- Two write ports: W0 for the ALU/EX result, W1 for the memory/load result.
- Same-cycle write-to-read bypass, plus a pending-write scoreboard that the ID stage uses to detect hazards and stall.
- Register 0 is hardwired to zero.

Parameters:
- DW, 32, data width in bits.
- AW, 5, register address width; depth is 2^AW entries, with entry 0 constant zero.
- NR, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  asynchronous active-high reset.
- rn  in  NR*AW  read addresses, flattened; port i occupies bits [i*AW +: AW].
- q  out  NR*DW  read data, flattened; port i occupies bits [i*DW +: DW].
- rbusy  out  NR  per-read-port stall flag: the operand is pending and is not being written this cycle.
- we0  in  1  write enable, port 0.
- wn0  in  AW  write address, port 0.
- d0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1.
- wn1  in  AW  write address, port 1.
- d1  in  DW  write data, port 1.
- iss  in  1  issue strobe: an instruction that will write iss_wn is leaving ID.
- iss_wn  in  AW  destination register of the issued instruction.
- pend  out  2^AW  scoreboard vector; bit r=1 means register r has an outstanding write.

Behaviour:
- Reset (clr=1, asynchronous): all entries 1..2^AW-1 go to 0 and pend goes to 0 immediately, regardless of clk.
  - While clr is high: q reads 0 for every address, unless bypassed from a write port; rbusy=0.
  - Writes and issues presented during reset are discarded.
- Writes, posedge clk:
  - wePort=1 and wnPort!=0 updates entry wnPort with dPort.
  - Writes to address 0 are ignored.
  - we0 and we1 to the same nonzero address in one cycle: W1 wins, and d0 is dropped.
  - Writes to different addresses both commit.
- Reads, combinational, zero latency. For each port i with address a=rn[i]:
  - a==0 -> q=0.
  - else if we1 and wn1==a -> q=d1.
  - else if we0 and wn0==a -> q=d0.
  - else q=entry[a].
  - Bypass priority matches write priority, so the value read equals the value stored after the edge.
- Scoreboard, posedge clk, per register r!=0:
  - set = iss and iss_wn==r.
  - clr_r = (we0 and wn0==r) or (we1 and wn1==r).
  - pend[r] next = set | (pend[r] & ~clr_r).
  - Set and clear on the same register in the same cycle: set wins, because a new producer supersedes the one completing.
  - iss with iss_wn==0 has no effect; pend[0] is always 0.
  - A write to a non-pending register is legal; the data commits and pend is unchanged.
- rbusy[i] = pend[rn[i]] and rn[i]!=0 and no enabled write port targets rn[i] this cycle.
  - Combinational; the bypass resolves the hazard in the completing cycle.
- No internal counters or FSM beyond the array and pend.
  - Registered state is (2^AW-1)*DW data bits plus 2^AW-1 pend bits.
  - All outputs derive from that state and the current inputs.

Test Plan:
- Assert clr for 2 cycles after random writes -> every q=0 and pend=0 on all NR ports. Assert clr between edges -> state clears without a clock edge.
- we0=1, wn0=3, d0=0x11111111 at edge; next cycle rn0=3 -> q0=0x11111111. Same cycle as the write, rn1=3 -> q1=0x11111111 via bypass.
- we0 and we1 both to r7, d0=0xAAAA0000, d1=0x0000BBBB -> combinational q=0x0000BBBB; after the edge entry r7=0x0000BBBB.
- we1=1, wn1=0, d1=0xFFFFFFFF; rn0=0 -> q0=0 both before and after the edge. iss with iss_wn=0 -> pend[0] stays 0.
- iss, iss_wn=5 -> pend[5]=1 and rbusy=1 for rn=5. Later we1, wn1=5, d1=0x55 -> rbusy=0 and q=0x55 that cycle; pend[5]=0 after the edge.
- pend[9]=1, then iss to 9 and we0 to 9 in the same cycle -> pend[9] stays 1 and entry r9 is updated with d0. NR=4, AW=4 build repeats the bypass and rbusy checks on all four ports.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, two write ports,
// the issue strobe and the pending-write scoreboard.
interface regfile_mp_if #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int NR = 2
);
   logic [NR*AW-1:0]   rn;
   logic [NR*DW-1:0]   q;
   logic [NR-1:0]      rbusy;
   logic               we0;
   logic [AW-1:0]      wn0;
   logic [DW-1:0]      d0;
   logic               we1;
   logic [AW-1:0]      wn1;
   logic [DW-1:0]      d1;
   logic               iss;
   logic [AW-1:0]      iss_wn;
   logic [(1<<AW)-1:0] pend;

   modport master (
      output rn, we0, wn0, d0, we1, wn1, d1, iss, iss_wn,
      input  q, rbusy, pend
   );

   modport slave (
      input  rn, we0, wn0, d0, we1, wn1, d1, iss, iss_wn,
      output q, rbusy, pend
   );
endinterface

// File: rtl/regfile_mp.sv
// Two-write, NR-read register file with same-cycle bypass and a pending-write
// scoreboard for ID-stage hazard detection. Entry 0 reads as constant zero.
module regfile_mp #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int NR = 2
) (
   input  logic         clk,
   input  logic         clr,
   regfile_mp_if.slave  bus
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0]      mem_q [1:DEPTH-1];
   logic [DW-1:0]      mem_d [1:DEPTH-1];
   logic [DEPTH-1:1]   pend_q;
   logic [DEPTH-1:1]   pend_d;
   logic [NR*DW-1:0]   q_all;
   logic [NR-1:0]      rbusy_all;

   // W1 is applied after W0 so it wins on a shared address.
   always_comb begin
      for (int r = 1; r < DEPTH; r++) begin
         mem_d[r] = mem_q[r];
         if (bus.we0 && bus.wn0 == AW'(r)) mem_d[r] = bus.d0;
         if (bus.we1 && bus.wn1 == AW'(r)) mem_d[r] = bus.d1;
      end
   end

   // A fresh issue supersedes a completing write to the same register.
   always_comb begin
      pend_d = pend_q;
      for (int r = 1; r < DEPTH; r++) begin
         logic set_r;
         logic clr_r;
         set_r = bus.iss && bus.iss_wn == AW'(r);
         clr_r = (bus.we0 && bus.wn0 == AW'(r)) || (bus.we1 && bus.wn1 == AW'(r));
         pend_d[r] = set_r | (pend_q[r] & ~clr_r);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int r = 1; r < DEPTH; r++) mem_q[r] <= '0;
         pend_q <= '0;
      end else begin
         for (int r = 1; r < DEPTH; r++) mem_q[r] <= mem_d[r];
         pend_q <= pend_d;
      end
   end

   // Bypass order mirrors the write order, so a read sees the post-edge value.
   always_comb begin
      q_all     = '0;
      rbusy_all = '0;
      for (int i = 0; i < NR; i++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] rd;
         logic          pnd;
         logic          hit0;
         logic          hit1;
         a    = bus.rn[i*AW +: AW];
         rd   = '0;
         pnd  = 1'b0;
         hit0 = bus.we0 && bus.wn0 == a;
         hit1 = bus.we1 && bus.wn1 == a;
         for (int r = 1; r < DEPTH; r++) begin
            if (a == AW'(r)) begin
               rd  = mem_q[r];
               pnd = pend_q[r];
            end
         end
         if (a != '0) begin
            if (hit1)      q_all[i*DW +: DW] = bus.d1;
            else if (hit0) q_all[i*DW +: DW] = bus.d0;
            else           q_all[i*DW +: DW] = rd;
         end
         rbusy_all[i] = pnd && (a != '0) && !hit0 && !hit1;
      end
   end

   assign bus.q     = q_all;
   assign bus.rbusy = rbusy_all;
   assign bus.pend  = {pend_q, 1'b0};

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default build (AW=5, NR=2) and a
// four-read-port build (AW=4, NR=4) sharing clock and reset.
module tb_regfile_mp;

   logic clk;
   logic clr;
   int   n_tot;
   int   n_bad;

   regfile_mp_if #(.DW(32), .AW(5), .NR(2)) bus_a ();
   regfile_mp_if #(.DW(32), .AW(4), .NR(4)) bus_b ();

   regfile_mp #(.DW(32), .AW(5), .NR(2)) u_dut_a (.clk(clk), .clr(clr), .bus(bus_a));
   regfile_mp #(.DW(32), .AW(4), .NR(4)) u_dut_b (.clk(clk), .clr(clr), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_a.rn = '0; bus_a.we0 = 0; bus_a.wn0 = '0; bus_a.d0 = '0;
      bus_a.we1 = 0; bus_a.wn1 = '0; bus_a.d1 = '0; bus_a.iss = 0; bus_a.iss_wn = '0;
      bus_b.rn = '0; bus_b.we0 = 0; bus_b.wn0 = '0; bus_b.d0 = '0;
      bus_b.we1 = 0; bus_b.wn1 = '0; bus_b.d1 = '0; bus_b.iss = 0; bus_b.iss_wn = '0;
   endtask

   task automatic clear_wr();
      bus_a.we0 = 0; bus_a.we1 = 0; bus_a.iss = 0;
      bus_b.we0 = 0; bus_b.we1 = 0; bus_b.iss = 0;
   endtask

   initial begin
      n_tot = 0;
      n_bad = 0;
      idle();
      clr = 1'b1;
      tick();
      tick();
      clr = 1'b0;
      tick();

      // populate some state, then reset over it
      bus_a.we0 = 1; bus_a.wn0 = 5'd1; bus_a.d0 = 32'hC0DE0001;
      bus_a.we1 = 1; bus_a.wn1 = 5'd2; bus_a.d1 = 32'hC0DE0002;
      bus_a.iss = 1; bus_a.iss_wn = 5'd4;
      tick();
      clear_wr();
      bus_a.rn = {5'd4, 5'd1};
      #1;
      chk("pre_rst_q0", bus_a.q[31:0], 32'hC0DE0001);
      chk("pre_rst_rbusy", 32'(bus_a.rbusy), 32'h2);

      bus_a.we0 = 1; bus_a.wn0 = 5'd2; bus_a.d0 = 32'hDEADBEEF;
      bus_a.iss = 1; bus_a.iss_wn = 5'd3;
      clr = 1'b1;
      #1;
      chk("rst_q0", bus_a.q[31:0], 32'h0);
      chk("rst_pend", bus_a.pend, 32'h0);
      chk("rst_rbusy", 32'(bus_a.rbusy), 32'h0);
      tick();
      tick();
      idle();
      clr = 1'b0;
      bus_a.rn = {5'd1, 5'd2};
      #1;
      chk("rst_discard_q0", bus_a.q[31:0], 32'h0);
      chk("rst_clear_q1", bus_a.q[63:32], 32'h0);
      chk("rst_discard_pend", bus_a.pend, 32'h0);
      tick();

      // asynchronous clear between clock edges
      bus_a.we0 = 1; bus_a.wn0 = 5'd6; bus_a.d0 = 32'h00000066;
      bus_a.iss = 1; bus_a.iss_wn = 5'd6;
      tick();
      clear_wr();
      bus_a.rn = {5'd0, 5'd6};
      #1;
      chk("async_pre_q0", bus_a.q[31:0], 32'h00000066);
      chk("async_pre_pend", bus_a.pend, 32'h00000040);
      #1 clr = 1'b1;
      #1;
      chk("async_q0", bus_a.q[31:0], 32'h0);
      chk("async_pend", bus_a.pend, 32'h0);
      clr = 1'b0;
      tick();

      // basic write and same-cycle bypass
      bus_a.we0 = 1; bus_a.wn0 = 5'd3; bus_a.d0 = 32'h11111111;
      bus_a.rn = {5'd3, 5'd0};
      #1;
      chk("bypass_q1", bus_a.q[63:32], 32'h11111111);
      tick();
      clear_wr();
      bus_a.rn = {5'd0, 5'd3};
      #1;
      chk("stored_q0", bus_a.q[31:0], 32'h11111111);

      // both ports to r7: W1 wins
      bus_a.we0 = 1; bus_a.wn0 = 5'd7; bus_a.d0 = 32'hAAAA0000;
      bus_a.we1 = 1; bus_a.wn1 = 5'd7; bus_a.d1 = 32'h0000BBBB;
      bus_a.rn = {5'd0, 5'd7};
      #1;
      chk("dual_bypass", bus_a.q[31:0], 32'h0000BBBB);
      tick();
      clear_wr();
      #1;
      chk("dual_stored", bus_a.q[31:0], 32'h0000BBBB);

      // different addresses both commit
      bus_a.we0 = 1; bus_a.wn0 = 5'd10; bus_a.d0 = 32'h1010_1010;
      bus_a.we1 = 1; bus_a.wn1 = 5'd11; bus_a.d1 = 32'h1111_0B0B;
      tick();
      clear_wr();
      bus_a.rn = {5'd11, 5'd10};
      #1;
      chk("two_wr_q0", bus_a.q[31:0], 32'h1010_1010);
      chk("two_wr_q1", bus_a.q[63:32], 32'h1111_0B0B);

      // writes and issues to r0 are ignored
      bus_a.we1 = 1; bus_a.wn1 = 5'd0; bus_a.d1 = 32'hFFFFFFFF;
      bus_a.iss = 1; bus_a.iss_wn = 5'd0;
      bus_a.rn = {5'd0, 5'd0};
      #1;
      chk("r0_before", bus_a.q[31:0], 32'h0);
      tick();
      clear_wr();
      #1;
      chk("r0_after", bus_a.q[31:0], 32'h0);
      chk("r0_pend", bus_a.pend, 32'h0);

      // scoreboard set, stall, resolve via W1
      bus_a.iss = 1; bus_a.iss_wn = 5'd5;
      tick();
      clear_wr();
      bus_a.rn = {5'd0, 5'd5};
      #1;
      chk("pend5_set", bus_a.pend, 32'h00000020);
      chk("rbusy5", 32'(bus_a.rbusy), 32'h1);
      bus_a.we1 = 1; bus_a.wn1 = 5'd5; bus_a.d1 = 32'h00000055;
      #1;
      chk("rbusy5_resolve", 32'(bus_a.rbusy), 32'h0);
      chk("q5_bypass", bus_a.q[31:0], 32'h00000055);
      tick();
      clear_wr();
      #1;
      chk("pend5_clear", bus_a.pend, 32'h0);
      chk("q5_stored", bus_a.q[31:0], 32'h00000055);

      // set beats clear on the same register
      bus_a.iss = 1; bus_a.iss_wn = 5'd9;
      tick();
      bus_a.iss = 1; bus_a.iss_wn = 5'd9;
      bus_a.we0 = 1; bus_a.wn0 = 5'd9; bus_a.d0 = 32'h00000099;
      tick();
      clear_wr();
      bus_a.rn = {5'd0, 5'd9};
      #1;
      chk("pend9_kept", bus_a.pend, 32'h00000200);
      chk("rbusy9", 32'(bus_a.rbusy), 32'h1);
      chk("q9_stored", bus_a.q[31:0], 32'h00000099);

      // four-port build: stall on all ports, then bypass on all ports
      bus_b.iss = 1; bus_b.iss_wn = 4'd5;
      tick();
      clear_wr();
      bus_b.rn = {4'd5, 4'd5, 4'd5, 4'd5};
      #1;
      chk("b_pend5", 32'(bus_b.pend), 32'h00000020);
      chk("b_rbusy_all", 32'(bus_b.rbusy), 32'hF);
      bus_b.we0 = 1; bus_b.wn0 = 4'd5; bus_b.d0 = 32'h00001234;
      #1;
      chk("b_rbusy_clear", 32'(bus_b.rbusy), 32'h0);
      for (int i = 0; i < 4; i++) chk($sformatf("b_q%0d_byp", i), bus_b.q[i*32 +: 32], 32'h00001234);
      tick();
      clear_wr();
      #1;
      chk("b_pend_done", 32'(bus_b.pend), 32'h0);

      bus_b.we0 = 1; bus_b.wn0 = 4'd6; bus_b.d0 = 32'hAAAA0000;
      bus_b.we1 = 1; bus_b.wn1 = 4'd6; bus_b.d1 = 32'h0000BBBB;
      bus_b.rn = {4'd6, 4'd5, 4'd0, 4'd6};
      #1;
      chk("b_q0_dual", bus_b.q[31:0], 32'h0000BBBB);
      chk("b_q1_zero", bus_b.q[63:32], 32'h0);
      chk("b_q2_old", bus_b.q[95:64], 32'h00001234);
      chk("b_q3_dual", bus_b.q[127:96], 32'h0000BBBB);
      tick();
      clear_wr();
      #1;
      chk("b_q3_stored", bus_b.q[127:96], 32'h0000BBBB);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
